vm_product_dispenser: RTL and testbench

//  Downstream (customer-side) end of the vending_machine output interface. Sinks the product

---
 rtl/vm_product_dispenser_pkg.sv | 39 +++
 rtl/vm_product_dispenser_if.sv | 22 ++
 rtl/vm_product_dispenser_change_accumulator.sv | 61 ++++++
 rtl/vm_product_dispenser.sv | 129 ++++++++++++
 tb/tb_vm_product_dispenser.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_product_dispenser_pkg.sv
// Shared types, widths and the denomination table for the product dispenser.
package vm_product_dispenser_pkg;

  localparam int PRODUCT_W = 3;
  localparam int DENOM_W   = 4;
  localparam int NUM_SLOTS = 8;
  localparam logic [DENOM_W-1:0] BAD_DENOM = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } disp_state_t;

  // Code 15 is not a denomination; it maps to zero so it can never add value.
  function automatic logic [15:0] denom_value_cents(logic [DENOM_W-1:0] code);
    logic [15:0] value;
    case (code)
      4'd0:    value = 16'd50000;
      4'd1:    value = 16'd20000;
      4'd2:    value = 16'd10000;
      4'd3:    value = 16'd5000;
      4'd4:    value = 16'd2000;
      4'd5:    value = 16'd1000;
      4'd6:    value = 16'd500;
      4'd7:    value = 16'd200;
      4'd8:    value = 16'd100;
      4'd9:    value = 16'd50;
      4'd10:   value = 16'd25;
      4'd11:   value = 16'd10;
      4'd12:   value = 16'd5;
      4'd13:   value = 16'd2;
      4'd14:   value = 16'd1;
      default: value = 16'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/vm_product_dispenser_if.sv
// Product request handshake between the vending machine and the dispenser.
interface vm_product_dispenser_if
  import vm_product_dispenser_pkg::*;
();

  logic [PRODUCT_W-1:0] product_code;
  logic                 product_valid;
  logic                 product_ready;

  modport master (
    output product_code,
    output product_valid,
    input  product_ready
  );

  modport slave (
    input  product_code,
    input  product_valid,
    output product_ready
  );

endinterface

// File: rtl/vm_product_dispenser_change_accumulator.sv
// Sums the returned change stream, counts items and tracks the no-change condition.
module vm_product_dispenser_change_accumulator
  import vm_product_dispenser_pkg::*;
#(
  parameter int CHANGE_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DENOM_W-1:0]  change_code,
  input  logic                change_valid,
  input  logic                no_change,
  input  logic                clear,
  output logic [CHANGE_W-1:0] change_total,
  output logic [7:0]          coin_count,
  output logic                no_change_flag,
  output logic                bad_code
);

  logic [CHANGE_W-1:0] total_reg;
  logic [7:0]          count_reg;
  logic                flag_reg;
  logic                bad_reg;
  logic                good_coin;
  logic                bad_coin;

  assign good_coin = change_valid && (change_code != BAD_DENOM);
  assign bad_coin  = change_valid && (change_code == BAD_DENOM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_reg <= '0;
      count_reg <= '0;
      flag_reg  <= 1'b0;
      bad_reg   <= 1'b0;
    end else begin
      bad_reg <= bad_coin && !clear;
      // Clear discards a coin arriving in the same cycle.
      if (clear) begin
        total_reg <= '0;
        count_reg <= '0;
      end else if (good_coin) begin
        total_reg <= total_reg + CHANGE_W'(denom_value_cents(change_code));
        if (count_reg != 8'hFF) begin
          count_reg <= count_reg + 8'd1;
        end
      end
      // A simultaneous no-change report outranks the clear.
      if (no_change) begin
        flag_reg <= 1'b1;
      end else if (clear) begin
        flag_reg <= 1'b0;
      end
    end
  end

  assign change_total   = total_reg;
  assign coin_count     = count_reg;
  assign no_change_flag = flag_reg;
  assign bad_code       = bad_reg;

endmodule

// File: rtl/vm_product_dispenser.sv
// Customer-side product dispenser: accepts requests, runs slot motors, tracks stock and change.
module vm_product_dispenser
  import vm_product_dispenser_pkg::*;
#(
  parameter int DISPENSE_CYCLES = 16,
  parameter int INIT_STOCK      = 10,
  parameter int CHANGE_W        = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vm_product_dispenser_if.slave prod,
  output logic [NUM_SLOTS-1:0] motor_en,
  output logic                 dispensed,
  output logic                 empty_err,
  output logic [NUM_SLOTS-1:0] stock_empty,
  input  logic                 restock,
  input  logic [PRODUCT_W-1:0] restock_code,
  input  logic [DENOM_W-1:0]   change_code,
  input  logic                 change_valid,
  input  logic                 no_change,
  input  logic                 clear,
  output logic [CHANGE_W-1:0]  change_total,
  output logic [7:0]           coin_count,
  output logic                 no_change_flag,
  output logic                 bad_code
);

  localparam int CNT_W = $clog2(DISPENSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [7:0] INIT_VAL = 8'(INIT_STOCK);

  disp_state_t                   state_reg;
  logic [CNT_W-1:0]              cnt_reg;
  logic [NUM_SLOTS-1:0]          motor_reg;
  logic                          dispensed_reg;
  logic                          empty_err_reg;
  logic [NUM_SLOTS-1:0][7:0]     stock_reg;
  logic [NUM_SLOTS-1:0][7:0]     stock_next;
  logic                          accept;
  logic                          avail;

  assign prod.product_ready = (state_reg == IDLE);
  assign accept = (state_reg == IDLE) && prod.product_valid;
  // A restock landing on the requested slot makes it available this cycle.
  assign avail  = (stock_reg[prod.product_code] != 8'd0) ||
                  (restock && (restock_code == prod.product_code));

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign stock_next[gi] =
          (restock && (restock_code == PRODUCT_W'(gi)))                 ? INIT_VAL :
          (accept && (prod.product_code == PRODUCT_W'(gi)) && avail)    ? stock_reg[gi] - 8'd1 :
                                                                          stock_reg[gi];
      assign stock_empty[gi] = (stock_reg[gi] == 8'd0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stock_reg[i] <= INIT_VAL;
      end
    end else begin
      stock_reg <= stock_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      motor_reg     <= '0;
      dispensed_reg <= 1'b0;
      empty_err_reg <= 1'b0;
    end else begin
      dispensed_reg <= 1'b0;
      empty_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (avail) begin
              state_reg <= RUN;
              cnt_reg   <= '0;
              motor_reg <= NUM_SLOTS'(1) << prod.product_code;
            end else begin
              empty_err_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg     <= DONE;
            motor_reg     <= '0;
            dispensed_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          motor_reg <= '0;
        end
      endcase
    end
  end

  assign motor_en  = motor_reg;
  assign dispensed = dispensed_reg;
  assign empty_err = empty_err_reg;

  vm_product_dispenser_change_accumulator #(
    .CHANGE_W(CHANGE_W)
  ) u_change (
    .clk           (clk),
    .rst_n         (rst_n),
    .change_code   (change_code),
    .change_valid  (change_valid),
    .no_change     (no_change),
    .clear         (clear),
    .change_total  (change_total),
    .coin_count    (coin_count),
    .no_change_flag(no_change_flag),
    .bad_code      (bad_code)
  );

endmodule

// File: tb/tb_vm_product_dispenser.sv
// Directed bench for the product dispenser: change table plus hand-written FSM sequences.
module tb_vm_product_dispenser;
  import vm_product_dispenser_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  motor_en;
  logic        dispensed;
  logic        empty_err;
  logic [7:0]  stock_empty;
  logic        restock;
  logic [2:0]  restock_code;
  logic [3:0]  change_code;
  logic        change_valid;
  logic        no_change;
  logic        clear;
  logic [23:0] change_total;
  logic [7:0]  coin_count;
  logic        no_change_flag;
  logic        bad_code;

  int checks;
  int errors;

  vm_product_dispenser_if prod_if ();

  vm_product_dispenser #(
    .DISPENSE_CYCLES(16),
    .INIT_STOCK     (10),
    .CHANGE_W       (24)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .prod          (prod_if),
    .motor_en      (motor_en),
    .dispensed     (dispensed),
    .empty_err     (empty_err),
    .stock_empty   (stock_empty),
    .restock       (restock),
    .restock_code  (restock_code),
    .change_code   (change_code),
    .change_valid  (change_valid),
    .no_change     (no_change),
    .clear         (clear),
    .change_total  (change_total),
    .coin_count    (coin_count),
    .no_change_flag(no_change_flag),
    .bad_code      (bad_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic        valid;
    logic        no_chg;
    logic        clr;
    logic [23:0] total;
    logic [7:0]  count;
    logic        flag;
    logic        bad;
  } chg_vec_t;

  chg_vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request and follows the run until ready returns (bounded).
  task automatic run_dispense(input logic [2:0] slot, input bit hold, input bit with_restock);
    logic [7:0] oh;
    int motor_cnt, disp_cnt, disp_at, ready_at;
    oh = 8'd1 << slot;
    prod_if.product_code  = slot;
    prod_if.product_valid = 1'b1;
    if (with_restock) begin
      restock      = 1'b1;
      restock_code = slot;
    end
    tick();
    restock = 1'b0;
    if (!hold) prod_if.product_valid = 1'b0;
    check("accept_ready_low", {31'd0, prod_if.product_ready}, 32'd0);
    check("accept_motor", {24'd0, motor_en}, {24'd0, oh});
    motor_cnt = 0; disp_cnt = 0; disp_at = 0; ready_at = 0;
    for (int n = 1; n <= 40; n++) begin
      if (motor_en == oh) motor_cnt++;
      if (dispensed) begin
        disp_cnt++;
        disp_at = n;
      end
      if (prod_if.product_ready) begin
        ready_at = n;
        break;
      end
      tick();
    end
    check("motor_cycles", motor_cnt, 16);
    check("dispensed_pulses", disp_cnt, 1);
    check("dispensed_cycle", disp_at, 17);
    check("ready_return_cycle", ready_at, 18);
    $display("dispense slot=%0d motor_cycles=%0d dispensed_at=%0d ready_at=%0d",
             slot, motor_cnt, disp_at, ready_at);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    checks = 0;
    errors = 0;
    vecs[0]  = '{4'd2,  1'b1, 1'b0, 1'b0, 24'd10000, 8'd1, 1'b0, 1'b0};
    vecs[1]  = '{4'd3,  1'b1, 1'b0, 1'b0, 24'd15000, 8'd2, 1'b0, 1'b0};
    vecs[2]  = '{4'd10, 1'b1, 1'b0, 1'b0, 24'd15025, 8'd3, 1'b0, 1'b0};
    vecs[3]  = '{4'd15, 1'b1, 1'b0, 1'b0, 24'd15025, 8'd3, 1'b0, 1'b1};
    vecs[4]  = '{4'd0,  1'b0, 1'b0, 1'b0, 24'd15025, 8'd3, 1'b0, 1'b0};
    vecs[5]  = '{4'd14, 1'b1, 1'b0, 1'b0, 24'd15026, 8'd4, 1'b0, 1'b0};
    vecs[6]  = '{4'd0,  1'b0, 1'b1, 1'b0, 24'd15026, 8'd4, 1'b1, 1'b0};
    vecs[7]  = '{4'd0,  1'b0, 1'b0, 1'b0, 24'd15026, 8'd4, 1'b1, 1'b0};
    vecs[8]  = '{4'd0,  1'b1, 1'b0, 1'b1, 24'd0,     8'd0, 1'b0, 1'b0};
    vecs[9]  = '{4'd0,  1'b0, 1'b1, 1'b1, 24'd0,     8'd0, 1'b1, 1'b0};
    vecs[10] = '{4'd0,  1'b1, 1'b0, 1'b0, 24'd50000, 8'd1, 1'b1, 1'b0};
    vecs[11] = '{4'd0,  1'b0, 1'b0, 1'b1, 24'd0,     8'd0, 1'b0, 1'b0};

    rst_n                 = 1'b0;
    prod_if.product_code  = 3'd0;
    prod_if.product_valid = 1'b0;
    restock               = 1'b0;
    restock_code          = 3'd0;
    change_code           = 4'd0;
    change_valid          = 1'b0;
    no_change             = 1'b0;
    clear                 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_ready", {31'd0, prod_if.product_ready}, 32'd1);
    check("rst_motor", {24'd0, motor_en}, 32'd0);
    check("rst_dispensed", {31'd0, dispensed}, 32'd0);
    check("rst_empty_err", {31'd0, empty_err}, 32'd0);
    check("rst_stock_empty", {24'd0, stock_empty}, 32'd0);
    check("rst_total", {8'd0, change_total}, 32'd0);
    check("rst_count", {24'd0, coin_count}, 32'd0);
    check("rst_flag", {31'd0, no_change_flag}, 32'd0);
    check("rst_bad", {31'd0, bad_code}, 32'd0);

    // Single dispense from slot 2
    run_dispense(3'd2, 1'b0, 1'b0);
    check("stock2_after", {24'd0, dut.stock_reg[2]}, 32'd9);

    // Drain slot 5 back-to-back, then one request too many
    for (int k = 0; k < 10; k++) run_dispense(3'd5, 1'b0, 1'b0);
    check("stock_empty_slot5", {24'd0, stock_empty}, 32'h20);
    prod_if.product_code  = 3'd5;
    prod_if.product_valid = 1'b1;
    tick();
    prod_if.product_valid = 1'b0;
    check("empty_err_pulse", {31'd0, empty_err}, 32'd1);
    check("empty_ready_kept", {31'd0, prod_if.product_ready}, 32'd1);
    check("empty_motor_off", {24'd0, motor_en}, 32'd0);
    $display("empty request slot=5 empty_err=%0b motor_en=%02h", empty_err, motor_en);
    tick();
    check("empty_err_one_cycle", {31'd0, empty_err}, 32'd0);
    check("empty_motor_still_off", {24'd0, motor_en}, 32'd0);
    restock      = 1'b1;
    restock_code = 3'd5;
    tick();
    restock = 1'b0;
    check("restock_clears_empty", {24'd0, stock_empty}, 32'd0);
    check("restock_value", {24'd0, dut.stock_reg[5]}, 32'd10);

    // Change-path vector table
    for (int v = 0; v < 12; v++) begin
      change_code  = vecs[v].code;
      change_valid = vecs[v].valid;
      no_change    = vecs[v].no_chg;
      clear        = vecs[v].clr;
      tick();
      check($sformatf("vec%0d_total", v), {8'd0, change_total}, {8'd0, vecs[v].total});
      check($sformatf("vec%0d_count", v), {24'd0, coin_count}, {24'd0, vecs[v].count});
      check($sformatf("vec%0d_flag", v), {31'd0, no_change_flag}, {31'd0, vecs[v].flag});
      check($sformatf("vec%0d_bad", v), {31'd0, bad_code}, {31'd0, vecs[v].bad});
      $display("vec %0d code=%0d valid=%0b nc=%0b clr=%0b total=%0d count=%0d flag=%0b bad=%0b",
               v, vecs[v].code, vecs[v].valid, vecs[v].no_chg, vecs[v].clr,
               change_total, coin_count, no_change_flag, bad_code);
    end
    change_valid = 1'b0;
    no_change    = 1'b0;
    clear        = 1'b0;

    // Coin count saturation
    change_code  = 4'd14;
    change_valid = 1'b1;
    for (int k = 0; k < 256; k++) tick();
    change_valid = 1'b0;
    check("count_saturates", {24'd0, coin_count}, 32'd255);
    check("total_after_256", {8'd0, change_total}, 32'd256);
    $display("saturation total=%0d count=%0d", change_total, coin_count);

    // Sticky no-change flag, then clear
    no_change = 1'b1;
    tick();
    no_change = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (no_change_flag) cnt++;
      tick();
    end
    check("flag_sticky_cycles", cnt, 100);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_flag", {31'd0, no_change_flag}, 32'd0);
    check("clear_total", {8'd0, change_total}, 32'd0);
    check("clear_count", {24'd0, coin_count}, 32'd0);
    $display("clear flag=%0b total=%0d count=%0d", no_change_flag, change_total, coin_count);

    // Reset in the middle of a motor run
    prod_if.product_code  = 3'd3;
    prod_if.product_valid = 1'b1;
    tick();
    prod_if.product_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("midrun_motor_on", {24'd0, motor_en}, 32'h08);
    rst_n = 1'b0;
    #1;
    check("async_motor_off", {24'd0, motor_en}, 32'd0);
    check("async_ready", {31'd0, prod_if.product_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (dispensed) cnt++;
      tick();
    end
    check("no_dispense_after_reset", cnt, 0);
    check("ready_after_reset", {31'd0, prod_if.product_ready}, 32'd1);
    for (int s = 0; s < 8; s++) begin
      check($sformatf("reload_stock%0d", s), {24'd0, dut.stock_reg[s]}, 32'd10);
    end
    $display("reset mid-run motor_en=%02h stock_empty=%02h", motor_en, stock_empty);

    // Accept with simultaneous restock, valid held across the run
    run_dispense(3'd1, 1'b1, 1'b1);
    check("restock_wins_stock1", {24'd0, dut.stock_reg[1]}, 32'd10);
    tick();
    check("second_accept_motor", {24'd0, motor_en}, 32'h02);
    check("second_accept_ready", {31'd0, prod_if.product_ready}, 32'd0);
    check("second_accept_stock1", {24'd0, dut.stock_reg[1]}, 32'd9);
    prod_if.product_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (prod_if.product_ready) begin
        cnt = 1;
        break;
      end
      tick();
    end
    check("second_run_completes", cnt, 1);
    $display("restock+accept slot=1 stock=%0d", dut.stock_reg[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
